instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 tb/tb_instr_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order word reads, and buffers returned instructions for decode.
// Optional build macro FETCH_MISALIGN_CHK_EN adds a sticky misalign_err flag for unaligned redirect targets.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic              misalign_err
`endif
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] QDEPTH_C = (CNT_W+1)'(QDEPTH);

  logic [ADDR_W-1:0] pc;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  fptr;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  n_alloc;
  logic [CNT_W-1:0]  n_pend;
  logic [CNT_W-1:0]  drop_cnt;
  logic [ADDR_W-1:0] slot_pc   [QDEPTH];
  logic [31:0]       slot_data [QDEPTH];

  logic              req_fire;
  logic              pop;
  logic              rsp_live;
  logic              rsp_drop;
  logic [CNT_W:0]    in_use;
  logic [CNT_W-1:0]  stale;
  logic [CNT_W-1:0]  drop_on_redirect;

  // Slots are a ring: [head, fptr) are FILLED, [fptr, tail) are PENDING.
  // Filled entries are always the oldest, so the head is FILLED exactly when n_alloc > n_pend.
  assign in_use         = {1'b0, n_alloc} + {1'b0, drop_cnt};
  assign imem_req_valid = rst_n & ~redirect_valid & (in_use < QDEPTH_C);
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign instr_valid    = (n_alloc != n_pend);
  assign instr          = instr_valid ? slot_data[head] : '0;
  assign instr_pc       = instr_valid ? slot_pc[head]   : '0;
  assign pop            = instr_valid & instr_ready;

  assign rsp_drop       = imem_rsp_valid & (drop_cnt != '0);
  assign rsp_live       = imem_rsp_valid & (drop_cnt == '0) & (n_pend != '0);

  // Every request still owed a response when a redirect lands becomes stale;
  // a response arriving in that very cycle already retires one of them.
  assign stale            = drop_cnt + n_pend + CNT_W'(req_fire);
  assign drop_on_redirect = stale - CNT_W'(imem_rsp_valid && (stale != '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      head     <= '0;
      fptr     <= '0;
      tail     <= '0;
      n_alloc  <= '0;
      n_pend   <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ~ADDR_W'(3);
      head     <= '0;
      fptr     <= '0;
      tail     <= '0;
      n_alloc  <= '0;
      n_pend   <= '0;
      drop_cnt <= drop_on_redirect;
    end else begin
      if (req_fire) begin
        pc   <= pc + ADDR_W'(4);
        tail <= tail + PTR_W'(1);
      end
      if (rsp_live) fptr <= fptr + PTR_W'(1);
      if (pop)      head <= head + PTR_W'(1);
      if (rsp_drop) drop_cnt <= drop_cnt - CNT_W'(1);
      n_alloc <= n_alloc + CNT_W'(req_fire) - CNT_W'(pop);
      n_pend  <= n_pend  + CNT_W'(req_fire) - CNT_W'(rsp_live);
    end
  end

  // Payload storage carries no reset; outputs are masked by instr_valid instead.
  always_ff @(posedge clk) begin
    if (req_fire) slot_pc[tail]   <= pc;
    if (rsp_live) slot_data[fptr] <= imem_rsp_data;
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      misalign_err <= 1'b0;
    else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
      misalign_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: in-order memory responder, directed stimulus, scoreboard monitor on the decode side.
// Build with FETCH_MISALIGN_CHK_EN defined to also exercise the misalign_err flag.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  int          errors;
  int          checks;
  int          pop_count;
  logic        mem_hold;
  logic [31:0] exp_q[$];
  logic [31:0] mem_q[$];

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign_err   (misalign_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ {a[31:16], 16'h0000};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory: returns responses in order, one per cycle, earliest the cycle after accept.
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        mem_q.delete();
        imem_rsp_valid = 1'b0;
      end else if (!mem_hold && mem_q.size() > 0) begin
        a = mem_q.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(a);
      end else begin
        imem_rsp_valid = 1'b0;
      end
      #1;
      if (rst_n && imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
    end
  end

  // Monitor: every instruction handed to decode must match the head of the expected queue.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && instr_valid && instr_ready) begin
        pop_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %h, expected none", instr_pc);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc, e);
          chk("instr_data", instr, mem_word(e));
        end
      end
    end
  end

  task automatic expect_seq(input logic [31:0] first, input int n);
    logic [31:0] a;
    a = first;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 32'd4;
    end
  endtask

  // Let decode consume until the total pop count reaches target, then stall it.
  task automatic consume(input int target);
    bit done;
    done = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (pop_count >= target) done = 1'b1;
    end
    instr_ready = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL consume_timeout: got %0d pops, expected %0d", pop_count, target);
    end
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    #2;
    chk("req_valid_during_redirect", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0; pop_count = 0;
    rst_n = 1'b0; mem_hold = 1'b0;
    imem_req_ready = 1'b1; instr_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
`endif

    // Warm-up: first fetch at 0x0, first instruction two cycles after its accept.
    expect_seq(32'h0, 3);
    rst_n = 1'b1;
    instr_ready = 1'b1;
    #2;
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    @(negedge clk); #2;
    chk("second_req_addr", imem_req_addr, 32'h4);
    chk("no_early_instr", {31'b0, instr_valid}, 32'd0);
    @(negedge clk); #2;
    chk("first_instr_valid", {31'b0, instr_valid}, 32'd1);
    chk("first_instr_pc", instr_pc, 32'h0);
    @(negedge clk);
    consume(3);

    // Decode stalled: queue fills to QDEPTH and requests stop.
    repeat (10) @(negedge clk);
    #2;
    chk("full_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("full_instr_valid", {31'b0, instr_valid}, 32'd1);
    chk("full_head_pc", instr_pc, 32'hC);
    @(negedge clk);
    expect_seq(32'hC, 2);
    consume(5);
    repeat (6) @(negedge clk);

    // Two requests left in flight, then redirect: both responses must be dropped.
    expect_seq(32'h14, 2);
    consume(7);
    mem_hold = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("inflight_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    mem_hold = 1'b0;
    expect_seq(32'h100, 2);
    redirect(32'h100);
    consume(9);
    repeat (4) @(negedge clk);
    chk("drop_cnt_zero", 32'(dut.drop_cnt), 32'd0);

    // Memory back-pressure: request held stable until accepted.
    imem_req_ready = 1'b0;
    expect_seq(32'h108, 2);
    consume(11);
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("held_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("held_req_addr", imem_req_addr, 32'h110);
      @(negedge clk);
    end
    imem_req_ready = 1'b1;
    expect_seq(32'h110, 2);
    consume(13);
    repeat (4) @(negedge clk);

    // Address wrap at the top of the space.
    expect_seq(32'hFFFF_FFF8, 4);
    redirect(32'hFFFF_FFF8);
    consume(17);
    repeat (4) @(negedge clk);

    // Unaligned redirect target is truncated to a word boundary.
    expect_seq(32'h100, 2);
    redirect(32'h102);
    consume(19);
    repeat (2) @(negedge clk);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("misalign_set", {31'b0, misalign_err}, 32'd1);
`endif
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    rst_n = 1'b0;
    @(negedge clk); #2;
    chk("rerst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rerst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rerst_instr_pc", instr_pc, 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("rerst_misalign", {31'b0, misalign_err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
